imem_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of the core's instruction-memory write port.
- Accepts a byte stream with a valid/ready handshake, such as a UART receiver.
- Assembles little-endian 32-bit words and drives `instr_mem_address`, `instr_mem_data` and `instr_mem_we` with one write pulse per word.
- Holds the core's `en` low while loading and raises it once the image is complete.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader_byte_assembler.sv | 65 ++++++
 rtl/imem_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_loader.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding and stream framing constants.
package moka_loader_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    HDR0   = 4'd1,
    HDR1   = 4'd2,
    WORD   = 4'd3,
    WRITE  = 4'd4,
    FINISH = 4'd5,
    CHK    = 4'd6,
    DONE   = 4'd7,
    ERROR  = 4'd8
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] instr_mem_address;
  logic [DATA_WIDTH-1:0] instr_mem_data;
  logic                  instr_mem_we;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, instr_mem_address, instr_mem_data, instr_mem_we
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, instr_mem_address, instr_mem_data, instr_mem_we
  );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler with a 2-bit byte index.
// With IMEM_LOADER_CHECKSUM_EN it also keeps a running XOR of shifted bytes.
module byte_assembler
  import moka_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_ready
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  xor_acc
`endif
);

  // Only the three earlier bytes need storage; the fourth is the live input.
  logic [23:0] sr_q, sr_d;
  logic [1:0]  idx_q, idx_d;

  assign word_next  = {byte_in, sr_q};
  assign word_ready = shift_en && (idx_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (clear) begin
      sr_d  = '0;
      idx_d = '0;
    end else if (shift_en) begin
      sr_d  = word_next[31:8];
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;

  assign xor_acc = xor_q;

  always_comb begin
    xor_d = xor_q;
    if (clear)         xor_d = '0;
    else if (shift_en) xor_d = xor_q ^ byte_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) xor_q <= '0;
    else     xor_q <= xor_d;
  end
`endif

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: count header + little-endian words into instruction memory,
// then enables the core. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import moka_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_CAPACITY = 1024,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  imem_loader_if.master          bus,
  output logic                   core_en,
  output logic                   busy,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] words_loaded
);

  localparam logic [COUNT_WIDTH-1:0] CAP = COUNT_WIDTH'(MEM_CAPACITY);

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [COUNT_WIDTH-1:0]  words_q, words_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    we_q, we_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    busy_q, busy_d;
  logic                    core_en_q, core_en_d;
  logic                    error_q, error_d;

  logic                    accept;
  logic                    asm_clear;
  logic                    asm_shift;
  logic [31:0]             asm_word;
  logic                    asm_word_ready;
  logic [COUNT_WIDTH-1:0]  hdr_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              asm_xor;
`endif

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .shift_en   (asm_shift),
    .byte_in    (bus.rx_data),
    .word_next  (asm_word),
    .word_ready (asm_word_ready)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .xor_acc    (asm_xor)
`endif
  );

  assign accept    = bus.rx_valid && rx_ready_q;
  assign hdr_count = COUNT_WIDTH'({bus.rx_data, count_q[7:0]});

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    words_d   = words_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    busy_d    = busy_q;
    core_en_d = core_en_q;
    error_d   = error_q;
    asm_clear = 1'b0;
    asm_shift = 1'b0;

    // start wins in every state, discarding any partially assembled word.
    if (start) begin
      state_d   = HDR0;
      words_d   = '0;
      addr_d    = '0;
      busy_d    = 1'b1;
      core_en_d = 1'b0;
      error_d   = 1'b0;
      asm_clear = 1'b1;
    end else begin
      unique case (state_q)
        HDR0: if (accept) begin
          count_d[7:0] = bus.rx_data;
          state_d      = HDR1;
        end
        HDR1: if (accept) begin
          count_d = hdr_count;
          if (hdr_count > CAP) begin
            state_d = ERROR;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else if (hdr_count == '0) begin
            state_d = FINISH;
          end else begin
            state_d = WORD;
          end
        end
        WORD: begin
          asm_shift = accept;
          if (asm_word_ready) begin
            data_d  = DATA_WIDTH'(asm_word);
            we_d    = 1'b1;
            state_d = WRITE;
          end
        end
        WRITE: begin
          addr_d  = addr_q + 1'b1;
          words_d = words_q + 1'b1;
          state_d = ((words_q + 1'b1) == count_q) ? FINISH : WORD;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        FINISH: state_d = CHK;
        CHK: if (accept) begin
          busy_d = 1'b0;
          if (bus.rx_data == asm_xor) begin
            state_d   = DONE;
            core_en_d = 1'b1;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
`else
        FINISH: begin
          state_d   = DONE;
          busy_d    = 1'b0;
          core_en_d = 1'b1;
        end
`endif
        IDLE, DONE, ERROR: state_d = state_q;
        default:           state_d = IDLE;
      endcase
    end

    rx_ready_d = state_d inside {HDR0, HDR1, WORD, CHK};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      core_en_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      core_en_q  <= core_en_d;
      error_q    <= error_d;
    end
  end

  assign bus.rx_ready          = rx_ready_q;
  assign bus.instr_mem_address = addr_q;
  assign bus.instr_mem_data    = data_q;
  assign bus.instr_mem_we      = we_q;
  assign core_en               = core_en_q;
  assign busy                  = busy_q;
  assign error                 = error_q;
  assign words_loaded          = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized images checked
// against a stream-level reference model of the load protocol.
module tb_imem_loader;

  localparam int CAP = 1024;

  logic        clk;
  logic        rst;
  logic        start;
  logic        core_en;
  logic        busy;
  logic        error;
  logic [15:0] words_loaded;

  int checks   = 0;
  int failures = 0;

  logic [63:0] wr_q[$];

  imem_loader_if #(.DATA_WIDTH(32)) bus ();

  imem_loader #(
    .DATA_WIDTH   (32),
    .MEM_CAPACITY (CAP),
    .COUNT_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .core_en      (core_en),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every strobe and checks the stream is stalled during it.
  always @(negedge clk) begin
    if (bus.instr_mem_we === 1'b1) begin
      wr_q.push_back({bus.instr_mem_address, bus.instr_mem_data});
      chk("rx_ready_in_write", {31'b0, bus.rx_ready}, 32'd0);
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_rx_ready"}, {31'b0, bus.rx_ready}, 32'd0);
    chk({tag, "_we"},       {31'b0, bus.instr_mem_we}, 32'd0);
    chk({tag, "_core_en"},  {31'b0, core_en}, 32'd0);
    chk({tag, "_busy"},     {31'b0, busy}, 32'd0);
    chk({tag, "_error"},    {31'b0, error}, 32'd0);
    chk({tag, "_addr"},     bus.instr_mem_address, 32'd0);
    chk({tag, "_data"},     bus.instr_mem_data, 32'd0);
    chk({tag, "_words"},    {16'b0, words_loaded}, 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    start = 1'b1;
    wr_q.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte with random idle cycles; returns on the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input int duty);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if ($urandom_range(99) < duty) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        if (bus.rx_ready === 1'b1) begin
          @(posedge clk);
          done = 1;
        end
      end else begin
        bus.rx_valid = 1'b0;
      end
      n++;
      if (!done && n > 300) begin
        chk("send_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
  endtask

  task automatic end_stream();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Reference model: header gives count; count > CAP rejects the image with no
  // writes; otherwise word i = payload bytes 4i..4i+3 little-endian at address i.
  task automatic run_image(input string tag, input int cnt, input logic [7:0] pl[$],
                           input int duty, input bit bad_chk);
    bit          hdr_err;
    bit          exp_err;
    int          n_wr;
    int          waited;
    logic [7:0]  x;
    logic [31:0] exp_word;
    logic [63:0] got;
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (bad_chk) return;
`endif
    hdr_err = (cnt > CAP);
    n_wr    = hdr_err ? 0 : cnt;
    exp_err = hdr_err;
    pulse_start();
    send_byte(cnt[7:0], duty);
    send_byte(cnt[15:8], duty);
    if (!hdr_err) begin
      x = 8'h00;
      for (int i = 0; i < 4 * cnt; i++) begin
        send_byte(pl[i], duty);
        x = x ^ pl[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad_chk ? (x ^ 8'h01) : x, duty);
      exp_err = bad_chk;
`endif
    end
    end_stream();
    waited = 0;
    while (busy === 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    chk({tag, "_nwrites"}, wr_q.size(), n_wr);
    for (int i = 0; i < n_wr && i < wr_q.size(); i++) begin
      exp_word = {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
      got = wr_q[i];
      chk({tag, "_addr"}, got[63:32], i);
      chk({tag, "_data"}, got[31:0], exp_word);
    end
    chk({tag, "_words"},    {16'b0, words_loaded}, n_wr);
    chk({tag, "_core_en"},  {31'b0, core_en}, {31'b0, !exp_err});
    chk({tag, "_error"},    {31'b0, error}, {31'b0, exp_err});
    chk({tag, "_rx_ready"}, {31'b0, bus.rx_ready}, 32'd0);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] none[$];
    int         cnt;

    rst = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Two-word image with valid held high.
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_image("two_words", 2, pl, 100, 1'b0);

    // Empty image.
`ifdef IMEM_LOADER_CHECKSUM_EN
    run_image("empty", 0, none, 100, 1'b0);
`else
    pulse_start();
    send_byte(8'h00, 100);
    send_byte(8'h00, 100);
    @(negedge clk);
    chk("empty_finish_core_en", {31'b0, core_en}, 32'd0);
    chk("empty_finish_busy",    {31'b0, busy}, 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("empty_done_core_en", {31'b0, core_en}, 32'd1);
    chk("empty_done_busy",    {31'b0, busy}, 32'd0);
    chk("empty_words",        {16'b0, words_loaded}, 32'd0);
    chk("empty_nwrites",      wr_q.size(), 32'd0);
`endif

    // Oversize header 01 04 = 1025 words.
    run_image("oversize", 1025, none, 100, 1'b0);
    pulse_start();
    chk("restart_error_clr", {31'b0, error}, 32'd0);
    chk("restart_busy",      {31'b0, busy}, 32'd1);

    // Randomized images with 50% valid duty, then random duty.
    for (int t = 0; t < 5; t++) begin
      cnt = (t == 0) ? 3 : int'($urandom_range(1, 6));
      pl.delete();
      for (int i = 0; i < 4 * cnt; i++) pl.push_back(8'($urandom_range(255)));
      run_image("random", cnt, pl, (t < 2) ? 50 : int'($urandom_range(20, 100)), 1'b0);
    end

    // Abort after five bytes, then a full one-word image.
    pulse_start();
    send_byte(8'h02, 100);
    send_byte(8'h00, 100);
    send_byte(8'hAA, 100);
    send_byte(8'hBB, 100);
    send_byte(8'hCC, 100);
    end_stream();
    chk("abort_no_write", wr_q.size(), 32'd0);
    pl = '{8'h37, 8'h05, 8'h00, 8'h80};
    run_image("abort_reload", 1, pl, 100, 1'b0);

    // Asynchronous reset in the middle of a word.
    pulse_start();
    send_byte(8'h01, 100);
    send_byte(8'h00, 100);
    send_byte(8'h11, 100);
    send_byte(8'h22, 100);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("post_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
    pl = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_image("chk_good", 1, pl, 100, 1'b0);
    run_image("chk_bad", 1, pl, 100, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
